ps2_wasd_receiver: RTL and testbench
====================================

PS2_WASD_RECEIVER -- requirements
Module: ps2_wasd_receiver

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4: the number of consecutive equal synchronized samples needed before ps2_clk is taken as a new level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000: the idle limit inside a frame, in clk cycles (1 ms at 50 MHz).
REQ-003 The block SHALL have parameter ARROWS_EN, default 1: when 1, the arrow keys also drive the direction outputs.
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock, 50 MHz; every register is clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ps2_clk, input, 1 bit: the PS/2 device clock, asynchronous to clk.
REQ-007 The block SHALL have port ps2_data, input, 1 bit: the PS/2 device data, asynchronous to clk.
REQ-008 The block SHALL have ports w, a, s, d, output, 1 bit each: a direction level, 1 while its key is held.
REQ-009 The block SHALL have port key_valid, output, 1 bit: a one-cycle pulse for each completed make or break event.
REQ-010 The block SHALL have port key_code, output, 8 bits: the scan code of the last event.
REQ-011 The block SHALL have port key_ext, output, 1 bit: the last event carried an E0 prefix.
REQ-012 The block SHALL have port key_break, output, 1 bit: the last event was a release.
REQ-013 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-015 The filtered ps2_clk level SHALL change only after FILTER_LEN consecutive equal synchronized samples.
REQ-016 A falling edge of the filtered clock SHALL produce a one-cycle sample strobe; ps2_data (synchronized) is sampled on that strobe.
REQ-017 The receive FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE: a strobe with data=0 goes to DATA with bit count 0; a strobe with data=1 is ignored.
- DATA: 8 strobes shift the data in LSB first, then the FSM goes to PARITY.
- PARITY: the sampled bit is stored, then the FSM goes to STOP.
- STOP: the frame is accepted only if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). The FSM then returns to IDLE in either case.
REQ-018 A rejected frame SHALL pulse frame_err for one cycle, the cycle after the stop strobe, and SHALL clear the E0 and F0 prefix flags.
REQ-019 In any state other than IDLE, the idle counter SHALL reset on each strobe.
REQ-020 When the idle counter reaches TIMEOUT_CYCLES-1 without a strobe, the FSM SHALL return to IDLE, pulse frame_err, and clear the prefix flags.
REQ-021 A timeout and a strobe in the same cycle SHALL resolve in favour of the strobe.
REQ-022 An accepted byte 0xE0 SHALL set the ext flag and produce no event.
REQ-023 An accepted byte 0xF0 SHALL set the brk flag and produce no event.
REQ-024 Any other accepted byte SHALL produce an event:
- key_code <= byte, key_ext <= ext, key_break <= brk;
- key_valid pulses one cycle, the cycle after the stop strobe;
- ext and brk are then cleared.
REQ-025 The direction mapping SHALL be, non-extended:
- 0x1D -> w;
- 0x1C -> a;
- 0x1B -> s;
- 0x23 -> d.
REQ-026 When ARROWS_EN=1, the extended mapping SHALL be:
- 0x75 -> w;
- 0x6B -> a;
- 0x72 -> s;
- 0x74 -> d.
REQ-027 A make event on a mapped key SHALL set that output in the same cycle key_valid pulses; a break event SHALL clear it.
REQ-028 WASD and arrow keys SHALL share the direction outputs; the last event wins, and a break of either key clears the output.
REQ-029 Unmapped codes SHALL still pulse key_valid and SHALL leave w/a/s/d unchanged.
REQ-030 Repeated make events (typematic) SHALL keep the output at 1 with no toggling.
REQ-031 Several direction outputs MAY be 1 at once; the block SHALL NOT apply priority or exclusion between them.

Reset
REQ-032 While reset=0, the block SHALL:
- force the FSM to IDLE;
- clear the bit counter, shift register, idle counter and the ext and brk flags;
- set w=a=s=d=0, key_valid=0, key_code=0x00, key_ext=0, key_break=0, frame_err=0;
- set the filtered clock and synchronizer flops to 1 (bus idle).
REQ-033 A reset asserted mid-frame SHALL discard the partial frame.
REQ-034 After reset releases, the first falling edge with data=0 SHALL start a new frame.

Verification
REQ-035 Frame 0x1D (parity 1, stop 1) at a 12.5 kHz device clock -> key_valid pulses once, key_code=0x1D, key_break=0, and w rises with key_valid while a=s=d=0.
REQ-036 Frames 0xF0 then 0x1D after REQ-035 -> one key_valid, key_break=1, w falls, and there is no event for the 0xF0 byte.
REQ-037 With ARROWS_EN=1, frames E0 6B then E0 F0 6B -> a=1 with key_ext=1, then a=0. With ARROWS_EN=0 -> a stays 0 and key_valid still pulses twice.
REQ-038 Frame 0x1C sent with even parity -> frame_err pulses once, there is no key_valid, and a stays 0. A following valid 0x1C frame -> a=1.
REQ-039 Send 5 bits, stop the device clock for 1.2 ms, then send a full 0x23 frame -> frame_err pulses at the timeout, then d=1.
REQ-040 Assert reset during bit 4 of a 0x1B frame while s is held -> all outputs are 0 immediately. After release, a full 0x1B frame -> s=1.

Source files
------------

// File: rtl/ps2_wasd_receiver.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the device clock, frames
// 11-bit odd-parity words, decodes E0/F0 prefixes and drives WASD/arrow direction levels.
module ps2_wasd_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ARROWS_EN      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w,
    output logic       a,
    output logic       s,
    output logic       d,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       frame_err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic [1:0]     clk_sync_q, data_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           strobe_q, sdata_q;
    state_e         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           parity_q;
    logic [TCW-1:0] idle_cnt_q;
    logic           ext_q, brk_q;
    logic [3:0]     dir_q;
    logic [3:0]     ev_mask_d;
    logic           key_valid_q, key_ext_q, key_break_q, frame_err_q;
    logic [7:0]     key_code_q;

    // Odd parity holds when data plus parity carries an odd number of ones.
    function automatic logic odd_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    // Direction mask {w,a,s,d} for a scan code; zero for unmapped codes.
    function automatic logic [3:0] dir_mask(input logic [7:0] code, input logic ext);
        logic [3:0] m;
        m = 4'b0000;
        if (!ext) begin
            case (code)
                8'h1D:   m = 4'b1000;
                8'h1C:   m = 4'b0100;
                8'h1B:   m = 4'b0010;
                8'h23:   m = 4'b0001;
                default: m = 4'b0000;
            endcase
        end else if (ARROWS_EN != 0) begin
            case (code)
                8'h75:   m = 4'b1000;
                8'h6B:   m = 4'b0100;
                8'h72:   m = 4'b0010;
                8'h74:   m = 4'b0001;
                default: m = 4'b0000;
            endcase
        end else begin
            m = 4'b0000;
        end
        return m;
    endfunction

    // Clock filter: the level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d     = clk_sync_q[1];
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    // Event mask for the byte held in the shift register.
    always_comb begin
        ev_mask_d = dir_mask(shift_q, ext_q);
    end

    // Synchronizers, filtered clock and the falling-edge sample strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            strobe_q    <= 1'b0;
            sdata_q     <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            strobe_q    <= filt_q & ~filt_d;
            sdata_q     <= data_sync_q[1];
        end
    end

    // Receive FSM, prefix decoding and registered event/direction outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            idle_cnt_q  <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            dir_q       <= 4'b0000;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == IDLE) begin
                idle_cnt_q <= '0;
                if (strobe_q && !sdata_q) begin
                    state_q   <= DATA;
                    bit_cnt_q <= 3'd0;
                end
            end else if (strobe_q) begin
                // A strobe wins over a coincident timeout.
                idle_cnt_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q   <= {sdata_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= sdata_q;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (sdata_q && odd_ok(shift_q, parity_q)) begin
                            if (shift_q == 8'hE0) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_q <= 1'b1;
                            end else begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= shift_q;
                                key_ext_q   <= ext_q;
                                key_break_q <= brk_q;
                                dir_q       <= brk_q ? (dir_q & ~ev_mask_d) : (dir_q | ev_mask_d);
                                ext_q       <= 1'b0;
                                brk_q       <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_q       <= 1'b0;
                            brk_q       <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (idle_cnt_q == TMO_LAST) begin
                state_q     <= IDLE;
                idle_cnt_q  <= '0;
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
            end else begin
                idle_cnt_q <= idle_cnt_q + TCW'(1);
            end
        end
    end

    assign w         = dir_q[3];
    assign a         = dir_q[2];
    assign s         = dir_q[1];
    assign d         = dir_q[0];
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_break = key_break_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_wasd_receiver.sv
// Bench for ps2_wasd_receiver: drives PS/2 frames into an arrows-enabled and an
// arrows-disabled instance and compares both against a key-event reference model.
module tb_ps2_wasd_receiver;

    localparam int FILT = 4;
    localparam int TMO  = 200;

    logic clk = 1'b0;
    logic reset, ps2_clk, ps2_data;
    logic w1, a1, s1, d1, kv1, ke1, kb1, fe1;
    logic w0, a0, s0, d0, kv0, ke0, kb0, fe0;
    logic [7:0] kc1, kc0;

    always #10 clk = ~clk;

    ps2_wasd_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .ARROWS_EN(1)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .w(w1), .a(a1), .s(s1), .d(d1), .key_valid(kv1), .key_code(kc1),
        .key_ext(ke1), .key_break(kb1), .frame_err(fe1)
    );

    ps2_wasd_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .ARROWS_EN(0)) dut_noarrow (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .w(w0), .a(a0), .s(s0), .d(d0), .key_valid(kv0), .key_code(kc0),
        .key_ext(ke0), .key_break(kb0), .frame_err(fe0)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pulse monitor: counts high cycles of the pulses and captures directions at each event.
    int kv_cnt1 = 0, kv_cnt0 = 0, fe_cnt1 = 0, fe_cnt0 = 0, w_fall1 = 0;
    logic [3:0] kv_dir1 = 4'b0000, kv_dir0 = 4'b0000;
    logic w1_prev = 1'b0;
    always @(negedge clk) begin
        if (kv1 === 1'b1) begin kv_cnt1++; kv_dir1 = {w1, a1, s1, d1}; end
        if (kv0 === 1'b1) begin kv_cnt0++; kv_dir0 = {w0, a0, s0, d0}; end
        if (fe1 === 1'b1) fe_cnt1++;
        if (fe0 === 1'b1) fe_cnt0++;
        if (w1_prev === 1'b1 && w1 === 1'b0) w_fall1++;
        w1_prev = w1;
    end

    // Reference model: key tables indexed w,a,s,d and event bookkeeping.
    logic [7:0] wasd_tab  [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    logic [7:0] arrow_tab [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
    bit         m_ext = 1'b0, m_brk = 1'b0, m_kv = 1'b0, m_fe = 1'b0;
    bit         m_kext = 1'b0, m_kbrk = 1'b0;
    bit [7:0]   m_code = 8'h00;
    bit [3:0]   m_dir1 = 4'b0000, m_dir0 = 4'b0000;
    int kv1b, kv0b, fe1b, fe0b;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        m_kv = 1'b0;
        m_fe = 1'b0;
        if (!ok) begin
            m_fe = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_kv = 1'b1; m_code = b; m_kext = m_ext; m_kbrk = m_brk;
            for (int i = 0; i < 4; i++) begin
                if (!m_ext && b == wasd_tab[i]) begin
                    m_dir1[3-i] = !m_brk;
                    m_dir0[3-i] = !m_brk;
                end
                if (m_ext && b == arrow_tab[i]) m_dir1[3-i] = !m_brk;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext = 1'b0; m_brk = 1'b0; m_kv = 1'b0; m_fe = 1'b0;
        m_kext = 1'b0; m_kbrk = 1'b0; m_code = 8'h00;
        m_dir1 = 4'b0000; m_dir0 = 4'b0000;
    endtask

    task automatic snap();
        kv1b = kv_cnt1; kv0b = kv_cnt0; fe1b = fe_cnt1; fe0b = fe_cnt0;
    endtask

    // One bit cell: data set while the clock is high, optional short clock glitch, then low half.
    task automatic send_bit(input bit v, input int half, input bit glitch);
        int g;
        ps2_data = v;
        if (glitch) begin
            g = $urandom_range(1, FILT - 1);
            wait_cyc(2);
            ps2_clk = 1'b0;
            wait_cyc(g);
            ps2_clk = 1'b1;
            wait_cyc(half - 2 - g);
        end else begin
            wait_cyc(half);
        end
        ps2_clk = 1'b0;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input int half, input bit glitchy);
        logic [10:0] fr;
        fr = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(fr[i], half, glitchy && ($urandom_range(0, 3) == 0));
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_after(input string tag);
        check({tag, "/kv1"}, kv_cnt1 - kv1b, 32'(m_kv));
        check({tag, "/kv0"}, kv_cnt0 - kv0b, 32'(m_kv));
        check({tag, "/fe1"}, fe_cnt1 - fe1b, 32'(m_fe));
        check({tag, "/fe0"}, fe_cnt0 - fe0b, 32'(m_fe));
        check({tag, "/key1"}, {kc1, ke1, kb1}, {m_code, m_kext, m_kbrk});
        check({tag, "/key0"}, {kc0, ke0, kb0}, {m_code, m_kext, m_kbrk});
        if (m_kv) begin
            check({tag, "/evdir1"}, kv_dir1, m_dir1);
            check({tag, "/evdir0"}, kv_dir0, m_dir0);
        end
        check({tag, "/dir1"}, {w1, a1, s1, d1}, m_dir1);
        check({tag, "/dir0"}, {w0, a0, s0, d0}, m_dir0);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int half, input bit glitchy);
        snap();
        send_bits(b, bad_par, bad_stop, 11, half, glitchy);
        model_frame(b, !bad_par && !bad_stop);
        wait_cyc(10);
        check_after(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/out1"}, {w1, a1, s1, d1, kv1, ke1, kb1, fe1, kc1}, 16'h0000);
        check({tag, "/out0"}, {w0, a0, s0, d0, kv0, ke0, kb0, fe0, kc0}, 16'h0000);
    endtask

    initial begin
        int base_wf, idx, half;
        bit ext, brk;
        logic [7:0] code;
        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(5);
        check_all_zero("reset");
        reset = 1'b1;
        wait_cyc(5);
        check_all_zero("post_reset");

        do_frame("w_make", 8'h1D, 1'b0, 1'b0, 20, 1'b0);
        do_frame("brk_pfx", 8'hF0, 1'b0, 1'b0, 20, 1'b0);
        do_frame("w_break", 8'h1D, 1'b0, 1'b0, 20, 1'b0);

        do_frame("e0_a", 8'hE0, 1'b0, 1'b0, 20, 1'b0);
        do_frame("left_make", 8'h6B, 1'b0, 1'b0, 20, 1'b0);
        do_frame("e0_b", 8'hE0, 1'b0, 1'b0, 20, 1'b0);
        do_frame("f0_b", 8'hF0, 1'b0, 1'b0, 20, 1'b0);
        do_frame("left_break", 8'h6B, 1'b0, 1'b0, 20, 1'b0);

        do_frame("a_badpar", 8'h1C, 1'b1, 1'b0, 20, 1'b0);
        do_frame("a_make", 8'h1C, 1'b0, 1'b0, 20, 1'b0);
        do_frame("a_badstop", 8'h1B, 1'b0, 1'b1, 20, 1'b0);

        // Partial frame then a stalled device clock: timeout must fire once.
        snap();
        send_bits(8'h23, 1'b0, 1'b0, 5, 20, 1'b0);
        wait_cyc(100);
        check("tmo_early", fe_cnt1 - fe1b, 32'd0);
        wait_cyc(300);
        model_frame(8'h00, 1'b0);
        check_after("timeout");
        do_frame("d_make", 8'h23, 1'b0, 1'b0, 20, 1'b0);

        // Timeout after an E0 prefix drops the prefix: 6B then arrives non-extended.
        do_frame("e0_c", 8'hE0, 1'b0, 1'b0, 20, 1'b0);
        snap();
        send_bits(8'h6B, 1'b0, 1'b0, 3, 20, 1'b0);
        wait_cyc(400);
        model_frame(8'h00, 1'b0);
        check_after("timeout_pfx");
        do_frame("plain_6b", 8'h6B, 1'b0, 1'b0, 20, 1'b0);

        base_wf = w_fall1;
        do_frame("typ1", 8'h1D, 1'b0, 1'b0, 12, 1'b0);
        do_frame("typ2", 8'h1D, 1'b0, 1'b0, 12, 1'b0);
        do_frame("typ3", 8'h1D, 1'b0, 1'b0, 12, 1'b0);
        check("typ_nofall", w_fall1 - base_wf, 32'd0);

        // Reset during bit 4 of a 0x1B frame while s is held.
        do_frame("s_make", 8'h1B, 1'b0, 1'b0, 20, 1'b0);
        send_bits(8'h1B, 1'b0, 1'b0, 5, 20, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(20);
        ps2_clk = 1'b0;
        wait_cyc(10);
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        ps2_clk = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(5);
        check_all_zero("rst_rel");
        do_frame("s_after_rst", 8'h1B, 1'b0, 1'b0, 20, 1'b0);

        // Random key events with occasional corrupted frames and clock glitches.
        for (int n = 0; n < 30; n++) begin
            idx  = $urandom_range(0, 8);
            ext  = (idx >= 4 && idx < 8) ? 1'b1 : 1'b0;
            brk  = $urandom_range(0, 1);
            code = (idx < 4) ? wasd_tab[idx] : (idx < 8) ? arrow_tab[idx-4] : 8'($urandom);
            half = $urandom_range(10, 25);
            if (ext || $urandom_range(0, 5) == 0)
                do_frame("rnd_e0", 8'hE0, $urandom_range(0, 11) == 0, 1'b0, half, 1'b1);
            if (brk)
                do_frame("rnd_f0", 8'hF0, 1'b0, $urandom_range(0, 11) == 0, half, 1'b1);
            do_frame("rnd_key", code, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 11) == 0, half, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
